// File: rtl/adder_share_arb_if.sv
// adder_share_arb_if: request/response bundle for the shared 24-bit adder arbiter
//   req_valid/req_ready/req_x/req_y : per-requester handshake and operands (requester i at [i*W +: W])
//   rsp_valid/rsp_ready/rsp_sum/rsp_id : single response channel, busy flags a stalled response
interface adder_share_arb_if #(
  parameter int NREQ = 4,
  parameter int W = 24,
  parameter int IDW = $clog2(NREQ)
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic rsp_valid;
  logic rsp_ready;
  logic [W:0] rsp_sum;
  logic [IDW-1:0] rsp_id;
  logic busy;
  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input req_ready, rsp_valid, rsp_sum, rsp_id, busy
  );
  modport slave (
    input req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id, busy
  );
endinterface

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin arbiter sharing one 24-bit carry-skip adder among NREQ requesters
//   clk, rst_n (async active-low), bus (adder_share_arb_if.slave)
//   optional (ADDER_ARB_GRANT_CNT_EN): cnt_clr in, grant_cnt out (16-bit saturating per requester)
module adder_share_arb #(
  parameter int NREQ = 4,
  parameter int W = 24,
  parameter int IDW = $clog2(NREQ)
) (
  input logic clk,
  input logic rst_n,
`ifdef ADDER_ARB_GRANT_CNT_EN
  input logic cnt_clr,
  output logic [NREQ*16-1:0] grant_cnt,
`endif
  adder_share_arb_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  // last bit of each carry-skip block: sizes 2,3,4,6,4,3,2
  localparam logic [23:0] BLK_END = 24'b1010_0100_0100_0001_0001_0010;
  state_t state, state_n;
  logic [IDW-1:0] rr_ptr, win;
  logic any_valid, can_accept, xfer;
  logic [W-1:0] op_x, op_y, sum;
  logic cout;
  logic [W:0] sum_q;
  logic [IDW-1:0] id_q;
  always_comb begin
    int idx;
    win = '0;
    any_valid = 1'b0;
    idx = 0;
    // walk backwards so the index closest to rr_ptr is the last to win
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (bus.req_valid[idx]) begin
        win = IDW'(idx);
        any_valid = 1'b1;
      end
    end
  end
  assign can_accept = state == EMPTY || bus.rsp_ready;
  assign xfer = rst_n && can_accept && any_valid;
  always_comb begin
    bus.req_ready = '0;
    bus.req_ready[win] = xfer;
  end
  assign op_x = bus.req_x[int'(win)*W +: W];
  assign op_y = bus.req_y[int'(win)*W +: W];
  // ripple inside each block; a fully-propagating block forwards its carry-in directly
  always_comb begin
    logic c, cb, p;
    sum = '0;
    c = 1'b0;
    cb = 1'b0;
    p = 1'b1;
    for (int i = 0; i < W; i++) begin
      sum[i] = op_x[i] ^ op_y[i] ^ c;
      p = p & (op_x[i] ^ op_y[i]);
      c = (op_x[i] & op_y[i]) | ((op_x[i] ^ op_y[i]) & c);
      c = BLK_END[i] ? (p ? cb : c) : c;
      cb = BLK_END[i] ? c : cb;
      p = BLK_END[i] ? 1'b1 : p;
    end
    cout = c;
  end
  always_comb state_n = xfer ? FULL : (state == FULL && bus.rsp_ready) ? EMPTY : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum_q <= '0;
      id_q <= '0;
      rr_ptr <= '0;
    end else if (xfer) begin
      sum_q <= {cout, sum};
      id_q <= win;
      rr_ptr <= win == IDW'(NREQ - 1) ? '0 : win + 1'b1;
    end
  assign bus.rsp_valid = state == FULL;
  assign bus.rsp_sum = sum_q;
  assign bus.rsp_id = id_q;
  assign bus.busy = state == FULL && !bus.rsp_ready;
`ifdef ADDER_ARB_GRANT_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) grant_cnt <= '0;
    else if (cnt_clr) grant_cnt <= '0;
    else if (xfer && grant_cnt[int'(win)*16 +: 16] != 16'hFFFF)
      grant_cnt[int'(win)*16 +: 16] <= grant_cnt[int'(win)*16 +: 16] + 16'd1;
`endif
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: randomized and directed checks of adder_share_arb against a behavioural model
module tb_adder_share_arb;
  localparam int NREQ = 4;
  localparam int W = 24;
  localparam int IDW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [NREQ-1:0] rv = '0;
  logic [W-1:0] rx [NREQ];
  logic [W-1:0] ry [NREQ];
  logic rrdy = 1'b0;
  logic m_valid;
  logic [W:0] m_sum;
  int m_id, m_ptr;
  logic [NREQ-1:0] granted;
  adder_share_arb_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();
`ifdef ADDER_ARB_GRANT_CNT_EN
  logic cnt_clr = 1'b0;
  logic [NREQ*16-1:0] grant_cnt;
`endif
  adder_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef ADDER_ARB_GRANT_CNT_EN
    .cnt_clr(cnt_clr),
    .grant_cnt(grant_cnt),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  always_comb begin
    bus.req_valid = rv;
    bus.rsp_ready = rrdy;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[i*W +: W] = rx[i];
      bus.req_y[i*W +: W] = ry[i];
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int pick();
    for (int k = 0; k < NREQ; k++)
      if (rv[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction
  // one cycle: check outputs against the model, clock, advance the model
  task automatic step();
    int w;
    logic [NREQ-1:0] er;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_sum = '0;
      m_id = 0;
      m_ptr = 0;
    end
    w = pick();
    er = '0;
    if (rst_n && w >= 0 && (!m_valid || rrdy)) er[w] = 1'b1;
    #1;
    check("req_ready", 64'(bus.req_ready), 64'(er));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
    check("rsp_sum", 64'(bus.rsp_sum), 64'(m_sum));
    check("rsp_id", 64'(bus.rsp_id), 64'(m_id));
    check("busy", 64'(bus.busy), 64'(m_valid && !rrdy));
    @(posedge clk);
    if (rst_n) begin
      if (er != 0) begin
        m_sum = {1'b0, rx[w]} + {1'b0, ry[w]};
        m_id = w;
        m_ptr = (w + 1) % NREQ;
        m_valid = 1'b1;
      end else if (rrdy) m_valid = 1'b0;
    end
    granted = er;
    @(negedge clk);
  endtask
  initial begin
    logic [IDW-1:0] held_id;
    logic [W:0] held_sum;
    for (int i = 0; i < NREQ; i++) begin
      rx[i] = '0;
      ry[i] = '0;
    end
    @(negedge clk);
    repeat (3) step();
    check("reset_sum", 64'(bus.rsp_sum), 64'h0);
    rst_n = 1'b1;
    rrdy = 1'b1;
    step();
    rx[2] = 24'h000005;
    ry[2] = 24'h00000A;
    rv = 4'b0100;
    #1 check("single_rdy", 64'(bus.req_ready), 64'b0100);
    step();
    rv = '0;
    check("single_sum", 64'(bus.rsp_sum), 64'h00000F);
    check("single_id", 64'(bus.rsp_id), 64'd2);
    rx[0] = 24'hFFFFFF;
    ry[0] = 24'h000001;
    rv = 4'b0001;
    step();
    check("carry_sum", 64'(bus.rsp_sum), 64'h1000000);
    check("carry_id", 64'(bus.rsp_id), 64'd0);
    ry[0] = 24'hFFFFFF;
    step();
    rv = '0;
    check("ovf_sum", 64'(bus.rsp_sum), 64'h1FFFFFE);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      rx[i] = 24'(i * 16);
      ry[i] = 24'(i);
    end
    rv = '1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("fair_id", 64'(bus.rsp_id), 64'(k % NREQ));
      check("fair_sum", 64'(bus.rsp_sum), 64'((k % NREQ) * 17));
    end
    rrdy = 1'b0;
    held_id = bus.rsp_id;
    held_sum = bus.rsp_sum;
    repeat (5) begin
      step();
      check("stall_id", 64'(bus.rsp_id), 64'(held_id));
      check("stall_sum", 64'(bus.rsp_sum), 64'(held_sum));
      check("stall_busy", 64'(bus.busy), 64'd1);
    end
    rrdy = 1'b1;
    #1 check("resume_rdy", 64'(bus.req_ready), 64'b0001);
    step();
    rrdy = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rv = '0;
    rrdy = 1'b1;
    step();
    check("no_replay", 64'(bus.rsp_valid), 64'd0);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (granted[i] || !rv[i]) begin
          rv[i] = 1'($urandom_range(0, 1));
          rx[i] = $urandom_range(0, 7) == 0 ? 24'hFFFFFF : 24'($urandom);
          ry[i] = $urandom_range(0, 7) == 0 ? 24'hFFFFFF : 24'($urandom);
        end
      rrdy = $urandom_range(0, 3) != 0;
      step();
    end
`ifdef ADDER_ARB_GRANT_CNT_EN
    rv = 4'b0010;
    rrdy = 1'b1;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    repeat (70000) @(negedge clk);
    check("cnt_sat", 64'(grant_cnt[31:16]), 64'hFFFF);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("cnt_clr", 64'(grant_cnt[31:16]), 64'h0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one 24-bit variable-block carry-skip adder datapath among NREQ requesters.
- Round-robin arbitration picks one request per cycle and drives that requester's operands into the adder (Cin=0).
- The 25-bit sum is registered together with the winner's ID.
- Valid/ready handshake on every request port and on the single response port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 24, operand width; fixed to 24 to match the adder instance.
- IDW, 2, requester ID width = clog2(NREQ).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept; one-hot or zero.
- req_x  in  NREQ*W  operand X, requester i at bits [i*W +: W].
- req_y  in  NREQ*W  operand Y, same packing as req_x.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_sum  out  W+1  registered X+Y, MSB is carry-out.
- rsp_id  out  IDW  index of the requester that produced rsp_sum.
- busy  out  1  rsp_valid held while rsp_ready=0 (stalled).

Behaviour:
- Reset (async, rst_n=0): rsp_valid=0, rsp_sum=0, rsp_id=0, rr_ptr=0, busy=0. req_ready is forced to 0 during reset.
- can_accept = ~rsp_valid | rsp_ready.
- Arbitration (combinational):
  - Scan indices rr_ptr, rr_ptr+1, ... mod NREQ; the first i with req_valid[i]=1 wins.
  - req_ready[i] = can_accept & (i==winner) & any_valid.
  - req_ready must not depend on rsp_ready through anything other than can_accept.
- Handshake: a request transfers when req_valid[i] & req_ready[i] on a rising edge.
  - Requester must hold req_valid and its operands stable until the transfer.
  - Withdrawing req_valid before transfer is a protocol violation; the block must not hang, and simply rearbitrates.
- Datapath:
  - Operands mux into the adder (Cin=0).
  - On transfer: rsp_sum <= {carry, sum[23:0]}, rsp_id <= winner, rsp_valid <= 1.
  - Latency is 1 cycle from transfer to rsp_valid.
- Response register FSM:
  - EMPTY (rsp_valid=0) -> FULL on transfer.
  - FULL & rsp_ready & no transfer -> EMPTY.
  - FULL & rsp_ready & transfer -> FULL with the new data. This gives back-to-back throughput of 1 per cycle.
  - FULL & ~rsp_ready -> hold all response outputs stable; req_ready=0; busy=1.
- Pointer: on transfer, rr_ptr <= winner+1 (mod NREQ). With no transfer, rr_ptr is unchanged.
- Boundaries:
  - Single active requester is granted every cycle it is valid, with no bubbles.
  - All requesters continuously valid get strict rotation 0,1,2,3,0,...
  - Sum overflow: X=Y=0xFFFFFF gives rsp_sum=0x1FFFFFE.
  - rr_ptr wraps at NREQ-1 -> 0 for non-power-of-two NREQ.
  - Reset asserted mid-stall drops the pending response; no replay.

Optional Feature:
- Macro ADDER_ARB_GRANT_CNT_EN.
- Defined:
  - Adds output grant_cnt [NREQ*16], one 16-bit counter per requester, packed as req_x.
  - A counter increments on each transfer of its requester and saturates at 0xFFFF.
  - Adds input cnt_clr (1 bit); synchronous clear of all counters, and clear wins over a same-cycle increment.
  - Counters reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, all req_valid=0 -> rsp_valid=0, req_ready=0000, rsp_sum=0.
- Single requester: req 2 with X=0x000005, Y=0x00000A, rsp_ready=1 -> req_ready=0100; next cycle rsp_valid=1, rsp_sum=0x00000F, rsp_id=2.
- Carry-out: req 0 with X=0xFFFFFF, Y=0x000001 -> rsp_sum=0x1000000, rsp_id=0.
- Fairness: all four requesters valid for 8 cycles, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1,2,3; one response per cycle.
- Backpressure: rsp_ready=0 for 5 cycles while responses are pending -> rsp_sum/rsp_id stable, busy=1, req_ready=0000. Release rsp_ready -> the next grant resumes at the saved rr_ptr.
- ADDER_ARB_GRANT_CNT_EN: 70000 grants to req 1 -> grant_cnt[1]=0xFFFF. cnt_clr pulsed together with a grant -> grant_cnt[1]=0.
